// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: divides clk into M_CLK, boxcar-decimates the bit stream,
// packs two 16-bit samples per word and writes them into a memory ring buffer.
module pdm_mic_capture #(
    parameter int          CLK_DIV    = 25,
    parameter int          DECIMATION = 64,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          BUF_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        m_data_i,
    output logic        m_clk_o,
    output logic        m_lrsel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic        ack_i,
    output logic        overrun_o,
    output logic [31:0] words_written_o
);

    localparam int          DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [15:0] DEC_LAST = 16'(DECIMATION - 1);
    localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * BUF_WORDS);

    typedef enum logic {IDLE, WRITE} state_t;

    logic [1:0]       sync_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             m_clk_reg;
    logic [15:0]      acc_reg;
    logic [15:0]      bit_cnt_reg;
    logic             half_reg;
    logic [15:0]      low_reg;
    logic [31:0]      word_reg;
    logic             word_valid_reg;
    state_t           state_reg;
    state_t           state_next;

    logic        pdm_bit;
    logic        div_wrap;
    logic        bit_strobe;
    logic [15:0] sample_sum;
    logic [31:0] addr_inc;

    assign pdm_bit    = sync_reg[1];
    assign div_wrap   = enable_i && (div_cnt_reg == DIV_LAST);
    // A bit is taken on the falling edge of M_CLK, i.e. a wrap while M_CLK is high
    assign bit_strobe = div_wrap && m_clk_reg;
    assign sample_sum = acc_reg + {15'd0, pdm_bit};
    assign addr_inc   = addr_o + 32'd4;

    assign m_clk_o   = m_clk_reg;
    assign m_lrsel_o = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], m_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable_i) begin
            div_cnt_reg <= '0;
            m_clk_reg   <= 1'b0;
        end else if (div_wrap) begin
            div_cnt_reg <= '0;
            m_clk_reg   <= ~m_clk_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Decimator and packer; word_valid_reg is a one-cycle handoff to the write FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg        <= '0;
            bit_cnt_reg    <= '0;
            half_reg       <= 1'b0;
            low_reg        <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (!enable_i) begin
                acc_reg     <= '0;
                bit_cnt_reg <= '0;
                half_reg    <= 1'b0;
                low_reg     <= '0;
            end else if (bit_strobe) begin
                if (bit_cnt_reg == DEC_LAST) begin
                    acc_reg     <= '0;
                    bit_cnt_reg <= '0;
                    if (half_reg) begin
                        word_reg       <= {sample_sum, low_reg};
                        word_valid_reg <= 1'b1;
                        half_reg       <= 1'b0;
                    end else begin
                        low_reg  <= sample_sum;
                        half_reg <= 1'b1;
                    end
                end else begin
                    acc_reg     <= sample_sum;
                    bit_cnt_reg <= bit_cnt_reg + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (word_valid_reg) state_next = WRITE;
            WRITE:   if (ack_i)          state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cyc_o = 1'b0;
        stb_o = 1'b0;
        we_o  = 1'b0;
        if (state_reg == WRITE) begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            we_o  = 1'b1;
        end
    end

    // No skid buffer: any word arriving while a write is outstanding is lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_o          <= BASE_ADDR;
            data_o          <= '0;
            overrun_o       <= 1'b0;
            words_written_o <= '0;
        end else begin
            if (state_reg == IDLE) begin
                if (word_valid_reg) data_o <= word_reg;
            end else begin
                if (word_valid_reg) overrun_o <= 1'b1;
                if (ack_i) begin
                    words_written_o <= words_written_o + 32'd1;
                    addr_o          <= (addr_inc == END_ADDR) ? BASE_ADDR : addr_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Self-checking bench for pdm_mic_capture: table-driven capture patterns checked against
// a bit-queue reference model, plus hand sequences for reset, overrun and enable gaps.
module tb_pdm_mic_capture;

    localparam int          CD       = 4;
    localparam int          DEC      = 16;
    localparam int          BW       = 4;
    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam int          WORD_CYC = 2 * CD * DEC * 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        m_data_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        m_clk_o, m_lrsel_o, cyc_o, stb_o, we_o, overrun_o;
    logic [31:0] addr_o, data_o, words_written_o;

    pdm_mic_capture #(
        .CLK_DIV(CD), .DECIMATION(DEC), .BASE_ADDR(BASE), .BUF_WORDS(BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .m_data_i(m_data_i),
        .m_clk_o(m_clk_o), .m_lrsel_o(m_lrsel_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .ack_i(ack_i),
        .overrun_o(overrun_o), .words_written_o(words_written_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mode = 0;          // 0 zeros, 1 ones, 2 alternating, 3 random
    bit          alt_phase = 1'b1;
    bit          ack_hold = 1'b1;
    int          ack_delay = 0;
    bit          bits_q[$];
    logic [31:0] exp_words[$];
    int          tot_acks = 0;
    logic [31:0] last_data = '0;

    typedef struct {
        int          pattern;
        int          n_words;
        int          delay;
        bit          use_const;
        logic [31:0] const_word;
    } vec_t;
    vec_t vecs[5];

    typedef struct {
        string       name;
        logic [31:0] expv;
    } rst_vec_t;
    rst_vec_t rst_tab[9];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] out_sel(input int i);
        case (i)
            0: return 32'(m_clk_o);
            1: return 32'(m_lrsel_o);
            2: return 32'(cyc_o);
            3: return 32'(stb_o);
            4: return 32'(we_o);
            5: return addr_o;
            6: return data_o;
            7: return 32'(overrun_o);
            8: return words_written_o;
            default: return 32'hdead_beef;
        endcase
    endfunction

    // Stimulus: a new PDM bit is presented on each M_CLK rise, half a period before capture
    logic prev_mclk = 1'b0;
    always begin
        bit b;
        int s0, s1;
        @(posedge clk);
        #1;
        if (m_clk_o && !prev_mclk) begin
            case (mode)
                0: b = 1'b0;
                1: b = 1'b1;
                2: begin b = alt_phase; alt_phase = ~alt_phase; end
                default: b = 1'($urandom_range(0, 1));
            endcase
            m_data_i = b;
            bits_q.push_back(b);
            if (bits_q.size() == 2 * DEC) begin
                s0 = 0;
                s1 = 0;
                for (int i = 0; i < DEC; i++) begin
                    s0 += int'(bits_q[i]);
                    s1 += int'(bits_q[DEC + i]);
                end
                exp_words.push_back({16'(s1), 16'(s0)});
                bits_q.delete();
            end
        end
        prev_mclk = m_clk_o;
    end

    // Slave: acknowledges after ack_delay wait cycles unless held off
    int wait_cnt = 0;
    always begin
        @(posedge clk);
        #2;
        if (ack_i) begin
            ack_i = 1'b0;
            wait_cnt = 0;
        end else if (cyc_o && stb_o && !ack_hold) begin
            if (wait_cnt >= ack_delay) ack_i = 1'b1;
            else wait_cnt++;
        end
    end

    // Monitor: one line per bus write, checked against model data and ring address
    logic [31:0] held_addr, held_data, ea, ed;
    bit in_cyc = 1'b0, hold_bad = 1'b0, post_ack = 1'b0;
    always begin
        @(negedge clk);
        if (post_ack) begin
            post_ack = 1'b0;
            check32("cyc_fall", 32'(cyc_o), 32'd0);
            check32("words_written", words_written_o, 32'(tot_acks));
        end
        if (cyc_o) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                held_addr = addr_o;
                held_data = data_o;
                hold_bad = 1'b0;
            end else if (addr_o !== held_addr || data_o !== held_data || !stb_o || !we_o) begin
                hold_bad = 1'b1;
            end
            if (ack_i) begin
                ea = BASE + 32'(4 * (tot_acks % BW));
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%h required=none", data_o);
                end else begin
                    ed = exp_words.pop_front();
                    check32("wr_data", data_o, ed);
                end
                check32("wr_addr", addr_o, ea);
                check32("wr_hold", 32'(hold_bad), 32'd0);
                $display("write %0d addr=%h data=%h", tot_acks, addr_o, data_o);
                tot_acks++;
                last_data = data_o;
                in_cyc = 1'b0;
                post_ack = 1'b1;
            end
        end else begin
            in_cyc = 1'b0;
        end
    end

    task automatic check_reset(input string tag);
        for (int i = 0; i < 9; i++)
            check32($sformatf("%s_%s", tag, rst_tab[i].name), out_sel(i), rst_tab[i].expv);
    endtask

    task automatic wait_words(input int target, input int budget, input string name);
        int n = 0;
        while (tot_acks < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check32(name, words_written_o, 32'(target));
    endtask

    task automatic wait_cyc(input int budget, input string name);
        int n = 0;
        while (!cyc_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check32(name, 32'(cyc_o), 32'd1);
    endtask

    task automatic settle();
        int n = 0;
        enable_i = 1'b0;
        while (cyc_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        bits_q.delete();
        exp_words.delete();
    endtask

    initial begin
        int n, target, base_ww;
        logic [31:0] h_addr;

        vecs[0] = '{1, 2, 0, 1'b1, 32'h0010_0010};
        vecs[1] = '{2, 2, 3, 1'b1, 32'h0008_0008};
        vecs[2] = '{0, 1, 0, 1'b1, 32'h0000_0000};
        vecs[3] = '{3, 3, 0, 1'b0, 32'h0};
        vecs[4] = '{3, 2, 20, 1'b0, 32'h0};
        rst_tab[0] = '{"m_clk", 32'd0};
        rst_tab[1] = '{"m_lrsel", 32'd0};
        rst_tab[2] = '{"cyc", 32'd0};
        rst_tab[3] = '{"stb", 32'd0};
        rst_tab[4] = '{"we", 32'd0};
        rst_tab[5] = '{"addr", BASE};
        rst_tab[6] = '{"data", 32'd0};
        rst_tab[7] = '{"overrun", 32'd0};
        rst_tab[8] = '{"words", 32'd0};

        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // M_CLK phase: first rise after CD cycles, period 2*CD
        mode = 0;
        enable_i = 1'b1;
        n = 0;
        while (!m_clk_o && n < 100) begin @(negedge clk); n++; end
        check32("mclk_first_rise", 32'(n), 32'(CD));
        n = 0;
        while (m_clk_o && n < 100) begin @(negedge clk); n++; end
        while (!m_clk_o && n < 100) begin @(negedge clk); n++; end
        check32("mclk_period", 32'(n), 32'(2 * CD));
        check32("lrsel", 32'(m_lrsel_o), 32'd0);
        settle();

        for (int v = 0; v < 5; v++) begin
            mode = vecs[v].pattern;
            ack_delay = vecs[v].delay;
            ack_hold = 1'b0;
            alt_phase = 1'b1;
            target = tot_acks + vecs[v].n_words;
            enable_i = 1'b1;
            wait_words(target, vecs[v].n_words * WORD_CYC + 200, $sformatf("vec%0d_words", v));
            if (vecs[v].use_const)
                check32($sformatf("vec%0d_data", v), last_data, vecs[v].const_word);
            settle();
        end

        // Enable dropped part-way into a sample, then a clean restart
        mode = 1;
        ack_delay = 0;
        enable_i = 1'b1;
        repeat (60) @(negedge clk);
        enable_i = 1'b0;
        bits_q.delete();
        exp_words.delete();
        repeat (2) @(negedge clk);
        check32("disable_mclk", 32'(m_clk_o), 32'd0);
        enable_i = 1'b1;
        wait_words(tot_acks + 1, WORD_CYC + 200, "reenable_words");
        check32("reenable_data", last_data, 32'h0010_0010);
        settle();

        // Overrun: ack withheld across the next word completion
        mode = 1;
        ack_hold = 1'b1;
        enable_i = 1'b1;
        wait_cyc(WORD_CYC + 200, "ovr_cyc_start");
        check32("ovr_before", 32'(overrun_o), 32'd0);
        h_addr = addr_o;
        base_ww = int'(words_written_o);
        repeat (WORD_CYC + WORD_CYC / 2) @(negedge clk);
        check32("ovr_set", 32'(overrun_o), 32'd1);
        check32("ovr_cyc_held", 32'(cyc_o), 32'd1);
        check32("ovr_addr_held", addr_o, h_addr);
        check32("ovr_data_held", data_o, 32'h0010_0010);
        ack_hold = 1'b0;
        wait_words(tot_acks + 1, 100, "ovr_one_write");
        enable_i = 1'b0;
        check32("ovr_words", words_written_o, 32'(base_ww + 1));
        check32("ovr_addr_adv", addr_o, (h_addr + 32'd4 == BASE + 32'(4 * BW)) ? BASE : h_addr + 32'd4);
        settle();
        check32("ovr_sticky", 32'(overrun_o), 32'd1);

        // Reset during an outstanding write
        ack_hold = 1'b1;
        enable_i = 1'b1;
        wait_cyc(WORD_CYC + 200, "rstw_cyc");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("rstw");
        @(negedge clk);
        enable_i = 1'b0;
        rst_n = 1'b1;
        tot_acks = 0;
        bits_q.delete();
        exp_words.delete();
        repeat (3) @(negedge clk);
        ack_hold = 1'b0;
        enable_i = 1'b1;
        wait_words(1, WORD_CYC + 200, "post_rst_words");
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
